// File: rtl/riscv_pkg.sv
// Shared branch encodings, predictor FSM states and BHT constants.
package riscv_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Weakly not-taken, so a cold entry flips after a single taken branch.
   localparam logic [1:0] BHT_RST = 2'b01;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_REDIRECT = 2'b01,
      ST_SQUASH   = 2'b10
   } bp_state_e;

   // 2-bit saturating counter step.
   function automatic logic [1:0] sat_upd(input logic [1:0] ctr, input logic taken);
      logic [1:0] r;
      r = ctr;
      if (taken && ctr != 2'b11) r = ctr + 2'b01;
      else if (!taken && ctr != 2'b00) r = ctr - 2'b01;
      return r;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch comparator: funct3 selects the taken condition.
module branch_cond_eval
   import riscv_pkg::*;
(
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic [2:0]  funct3_i,
   output logic        taken_o
);

   // Evaluate the selected comparison; reserved encodings never take.
   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = (rs1_i == rs2_i);
         F3_BNE:  taken_o = (rs1_i != rs2_i);
         F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
         F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
         F3_BLTU: taken_o = (rs1_i <  rs2_i);
         F3_BGEU: taken_o = (rs1_i >= rs2_i);
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with EX-stage resolve, redirect and squash window.
module branch_predict_ctrl
   import riscv_pkg::*;
#(
   parameter int BHT_IDX_W  = 4,
   parameter int SQUASH_CYC = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [2:0]  ex_br_type,
   input  logic [31:0] ex_rs1,
   input  logic [31:0] ex_rs2,
   input  logic        stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic [15:0] br_count,
   output logic [15:0] mispred_count
);

   localparam int NENT = 1 << BHT_IDX_W;
   localparam int SQ_W = (SQUASH_CYC < 2) ? 1 : $clog2(SQUASH_CYC);
   localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQUASH_CYC - 1);

   logic [1:0]           bht_q [NENT];
   bp_state_e            state_q, state_d;
   logic [SQ_W-1:0]      sq_cnt_q, sq_cnt_d;
   logic                 redir_q;
   logic [31:0]          redir_pc_q, redir_pc_d;
   logic [15:0]          br_cnt_q, mis_cnt_q;

   logic                 taken, resolve, mispred;
   logic [BHT_IDX_W-1:0] if_idx, ex_idx;

   // Only the index bits of the PCs feed the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0],
                             ex_pc[31:BHT_IDX_W+2], ex_pc[1:0]};

   assign if_idx = if_pc[BHT_IDX_W+1:2];
   assign ex_idx = ex_pc[BHT_IDX_W+1:2];

   branch_cond_eval u_cond (
      .rs1_i    (ex_rs1),
      .rs2_i    (ex_rs2),
      .funct3_i (ex_br_type),
      .taken_o  (taken)
   );

   // Lookup reads the registered table, so a same-cycle update is not seen.
   assign pred_taken = if_valid & bht_q[if_idx][1];

   assign resolve = (state_q == ST_RUN) & ex_valid & ex_is_branch & ~stall;
   assign mispred = resolve & (taken != ex_pred_taken);

   assign redir_pc_d = taken ? ex_target : (ex_pc + 32'd4);

   // BHT: train the resolved branch's counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NENT; i++) bht_q[i] <= BHT_RST;
      end else if (resolve) begin
         bht_q[ex_idx] <= sat_upd(bht_q[ex_idx], taken);
      end
   end

   // FSM next state: REDIRECT is a single cycle, SQUASH counts unstalled slots.
   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      case (state_q)
         ST_RUN: if (mispred) state_d = ST_REDIRECT;
         ST_REDIRECT: begin
            state_d  = ST_SQUASH;
            sq_cnt_d = '0;
         end
         ST_SQUASH: if (!stall) begin
            if (sq_cnt_q == SQ_LAST) begin
               state_d  = ST_RUN;
               sq_cnt_d = '0;
            end else begin
               sq_cnt_d = sq_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = ST_RUN;
            sq_cnt_d = '0;
         end
      endcase
   end

   // FSM state and squash count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         sq_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sq_cnt_q <= sq_cnt_d;
      end
   end

   // Registered redirect pulse; the address holds between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redir_q    <= 1'b0;
         redir_pc_q <= '0;
      end else begin
         redir_q <= mispred;
         if (mispred) redir_pc_q <= redir_pc_d;
      end
   end

   // Resolve and misprediction statistics, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (resolve) br_cnt_q  <= br_cnt_q + 16'd1;
         if (mispred) mis_cnt_q <= mis_cnt_q + 16'd1;
      end
   end

   assign redirect_valid = redir_q;
   assign flush          = redir_q;
   assign redirect_pc    = redir_pc_q;
   assign br_count       = br_cnt_q;
   assign mispred_count  = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench: directed table, multi-cycle sequences and random traffic
// against a behavioural predictor model.
module tb_branch_predict_ctrl;

   localparam int SQ = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid, ex_is_branch, ex_pred_taken, stall;
   logic [31:0] ex_pc, ex_target, ex_rs1, ex_rs2;
   logic [2:0]  ex_br_type;
   logic        redirect_valid, flush;
   logic [31:0] redirect_pc;
   logic [15:0] br_count, mispred_count;

   int errors = 0;
   int checks = 0;

   // model state
   int          bht_m [16];
   int          brc_m, mpc_m;
   bit          rv_m;
   logic [31:0] rpc_m;
   bit          redir_pend;
   int          sq_left;

   branch_predict_ctrl #(.BHT_IDX_W(4), .SQUASH_CYC(SQ)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
      .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_br_type(ex_br_type), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) <  $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a <  b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
      brc_m = 0; mpc_m = 0; rv_m = 0; rpc_m = 0; redir_pend = 0; sq_left = 0;
   endfunction

   task automatic idle();
      ex_valid = 0; ex_is_branch = 0; stall = 0;
   endtask

   task automatic br(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b, input logic pr);
      ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_target = tgt;
      ex_br_type = f3; ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pr;
   endtask

   // One clock: check the lookup, advance the model, check registered outputs.
   task automatic cycle();
      bit t;
      int ix;
      #1;
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, (if_valid && bht_m[if_pc[5:2]] >= 2)});
      rv_m = 0;
      if (redir_pend) begin
         redir_pend = 0;
         sq_left = SQ;
      end else if (sq_left > 0) begin
         if (!stall) sq_left--;
      end else if (ex_valid && ex_is_branch && !stall) begin
         t  = cond_m(ex_br_type, ex_rs1, ex_rs2);
         ix = ex_pc[5:2];
         bht_m[ix] = t ? ((bht_m[ix] < 3) ? bht_m[ix] + 1 : 3)
                       : ((bht_m[ix] > 0) ? bht_m[ix] - 1 : 0);
         brc_m = (brc_m + 1) & 16'hFFFF;
         if (t != ex_pred_taken) begin
            mpc_m = (mpc_m + 1) & 16'hFFFF;
            rv_m = 1;
            rpc_m = t ? ex_target : ex_pc + 32'd4;
            redir_pend = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, rv_m});
      chk("flush", {31'd0, flush}, {31'd0, rv_m});
      chk("redirect_pc", redirect_pc, rpc_m);
      chk("br_count", {16'd0, br_count}, brc_m);
      chk("mispred_count", {16'd0, mispred_count}, mpc_m);
   endtask

   task automatic do_reset();
      idle();
      if_valid = 0; if_pc = 0;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst flush", {31'd0, flush}, 32'd0);
      chk("rst redirect_pc", redirect_pc, 32'd0);
      chk("rst br_count", {16'd0, br_count}, 32'd0);
      chk("rst mispred_count", {16'd0, mispred_count}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a, b;
      bit          exp_t;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{3'b000, 32'd5,        32'd5, 1'b1};
      tbl[1] = '{3'b000, 32'd5,        32'd6, 1'b0};
      tbl[2] = '{3'b001, 32'd5,        32'd6, 1'b1};
      tbl[3] = '{3'b100, 32'hFFFFFFFF, 32'd1, 1'b1};
      tbl[4] = '{3'b110, 32'hFFFFFFFF, 32'd1, 1'b0};
      tbl[5] = '{3'b101, 32'h80000000, 32'd0, 1'b0};
      tbl[6] = '{3'b111, 32'h80000000, 32'd0, 1'b1};
      tbl[7] = '{3'b010, 32'd1,        32'd1, 1'b0};
      tbl[8] = '{3'b011, 32'd0,        32'd9, 1'b0};
      tbl[9] = '{3'b101, 32'd7,        32'd7, 1'b1};

      rst_n = 1; if_valid = 0; if_pc = 0; ex_pc = 0; ex_target = 0;
      ex_br_type = 0; ex_rs1 = 0; ex_rs2 = 0; ex_pred_taken = 0;
      idle();
      model_reset();
      do_reset();

      // Reset state: cold entry predicts not-taken.
      if_valid = 1; if_pc = 32'h100;
      #1 chk("cold pred 0x100", {31'd0, pred_taken}, 32'd0);
      cycle();

      // Comparator table, once with each carried prediction.
      for (int i = 0; i < 10; i++) begin
         do_reset();
         br(32'h40, 32'h80, tbl[i].f3, tbl[i].a, tbl[i].b, 1'b0);
         cycle();
         chk("tbl p0 rv", {31'd0, redirect_valid}, {31'd0, tbl[i].exp_t});
         chk("tbl p0 rpc", redirect_pc, tbl[i].exp_t ? 32'h80 : 32'h0);
         do_reset();
         br(32'h40, 32'h80, tbl[i].f3, tbl[i].a, tbl[i].b, 1'b1);
         cycle();
         chk("tbl p1 rv", {31'd0, redirect_valid}, {31'd0, !tbl[i].exp_t});
         chk("tbl p1 rpc", redirect_pc, tbl[i].exp_t ? 32'h0 : 32'h44);
      end

      // BEQ mispredict, then slots during REDIRECT/SQUASH are dropped.
      do_reset();
      br(32'h40, 32'h80, 3'b000, 32'd5, 32'd5, 1'b0);
      cycle();
      chk("beq rv", {31'd0, redirect_valid}, 32'd1);
      chk("beq rpc", redirect_pc, 32'h80);
      chk("beq mispred", {16'd0, mispred_count}, 32'd1);
      for (int i = 0; i < 1 + SQ; i++) begin
         br(32'h50, 32'h200, 3'b001, 32'd1, 32'd2, 1'b0);
         cycle();
      end
      chk("squash br_count", {16'd0, br_count}, 32'd1);
      chk("squash rpc hold", redirect_pc, 32'h80);
      idle(); if_valid = 1; if_pc = 32'h40;
      #1 chk("entry0 now 10", {31'd0, pred_taken}, 32'd1);
      cycle();

      // Saturation at one index, then a single not-taken step back.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         br(32'h48, 32'h300, 3'b001, 32'd1, 32'd2, 1'b1);
         cycle();
      end
      br(32'h48, 32'h300, 3'b001, 32'd3, 32'd3, 1'b1);
      cycle();
      chk("sat mispred", {16'd0, mispred_count}, 32'd1);
      chk("sat rpc", redirect_pc, 32'h4C);
      idle(); if_valid = 1; if_pc = 32'h48;
      #1 chk("sat pred still 1", {31'd0, pred_taken}, 32'd1);
      cycle();
      for (int i = 0; i < SQ; i++) cycle();

      // Stall through REDIRECT and part of SQUASH.
      do_reset();
      br(32'h40, 32'h80, 3'b000, 32'd1, 32'd1, 1'b0);
      cycle();
      br(32'h60, 32'h90, 3'b000, 32'd1, 32'd1, 1'b0);
      stall = 1;
      for (int i = 0; i < 6; i++) cycle();
      stall = 0;
      for (int i = 0; i < SQ; i++) cycle();
      chk("stall squash br_count", {16'd0, br_count}, 32'd1);
      cycle();
      chk("post squash br_count", {16'd0, br_count}, 32'd2);
      chk("post squash rv", {31'd0, redirect_valid}, 32'd1);
      chk("post squash rpc", redirect_pc, 32'h90);
      idle();
      for (int i = 0; i < 1 + SQ; i++) cycle();

      // Asynchronous reset mid-SQUASH, then a fresh mispredict.
      br(32'h40, 32'h80, 3'b000, 32'd1, 32'd2, 1'b1);
      cycle();
      cycle();
      do_reset();
      cycle();
      chk("after rst no pulse", {31'd0, redirect_valid}, 32'd0);
      br(32'h44, 32'h400, 3'b110, 32'd1, 32'd2, 1'b0);
      cycle();
      chk("after rst rv", {31'd0, redirect_valid}, 32'd1);
      chk("after rst rpc", redirect_pc, 32'h400);

      // Random traffic against the model.
      idle();
      for (int i = 0; i < 1500; i++) begin
         if_valid      = 1'($urandom);
         if_pc         = 32'h40 + 32'($urandom_range(0, 31)) * 4;
         ex_valid      = ($urandom_range(0, 9) < 8);
         ex_is_branch  = ($urandom_range(0, 9) < 7);
         ex_pc         = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC
                                                      : 32'h40 + 32'($urandom_range(0, 31)) * 4;
         ex_target     = $urandom;
         ex_br_type    = 3'($urandom);
         ex_rs1        = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
         ex_rs2        = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
         ex_pred_taken = 1'($urandom);
         stall         = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter BHT_IDX_W, default 4, meaning log2 of the number of BHT entries (16).
REQ-002 SHALL have parameter SQUASH_CYC, default 3, meaning the number of wrong-path EX slots discarded after a redirect.
REQ-003 SHALL have ports, one per line, as follows (clk and rst_n first):
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  reset; asynchronous, active-low.
if_valid  in  1  fetch slot valid.
if_pc  in  32  fetch PC.
pred_taken  out  1  BHT prediction for if_pc; combinational.
ex_valid  in  1  EX slot valid.
ex_is_branch  in  1  EX instruction is a conditional branch.
ex_pc  in  32  EX instruction PC.
ex_target  in  32  computed branch target.
ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
ex_br_type  in  3  branch funct3.
ex_rs1  in  32  first operand.
ex_rs2  in  32  second operand.
stall  in  1  pipeline stall; freezes EX evaluation and the squash count.
redirect_valid  out  1  one-cycle redirect pulse; registered.
redirect_pc  out  32  fetch redirect address; registered.
flush  out  1  kill IF/ID; equal to redirect_valid.
br_count  out  16  branches resolved.
mispred_count  out  16  mispredictions.

Function
REQ-004 SHALL use the branch taken condition by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 are never taken.
REQ-005 SHALL hold BHT entries as 2-bit saturating counters indexed by pc[BHT_IDX_W+1:2]; prediction is taken when counter[1]=1.
REQ-006 SHALL produce pred_taken = 0 when if_valid=0.
REQ-007 SHALL resolve a branch only in a cycle where ex_valid & ex_is_branch & !stall and the FSM is in RUN.
REQ-008 SHALL, on resolve, update the counter: taken saturates up at 11, not-taken saturates down at 00; br_count increments and wraps at 16 bits.
REQ-009 SHALL read the old counter value when a lookup and an update hit the same index in the same cycle; the write is visible the next cycle.
REQ-010 SHALL declare a misprediction when the actual outcome differs from ex_pred_taken; mispred_count then increments and wraps.
REQ-011 SHALL, on misprediction at cycle t, drive redirect_valid=flush=1 for exactly cycle t+1, with redirect_pc = ex_target if taken, else ex_pc+4 (mod 2^32).
REQ-012 SHALL implement FSM states RUN, REDIRECT and SQUASH with these transitions:
- RUN -> REDIRECT on misprediction.
- REDIRECT -> SQUASH unconditionally after one cycle.
- SQUASH -> RUN after SQUASH_CYC non-stalled cycles.
REQ-013 SHALL ignore EX inputs in REDIRECT and SQUASH: no BHT update, no counter change, no new redirect.
REQ-014 SHALL not advance the squash counter while stall=1; REDIRECT still lasts exactly one cycle regardless of stall.
REQ-015 SHALL hold redirect_pc at its last value when redirect_valid=0.
REQ-016 SHALL take no resolve action on non-branch or invalid EX slots.

Reset
REQ-017 SHALL, on rst_n low (asynchronous), set every BHT entry to 01, set the FSM to RUN with the squash count at 0, set br_count=mispred_count=0, and set redirect_valid=flush=0 and redirect_pc=0.
REQ-018 SHALL, on reset asserted mid-REDIRECT or mid-SQUASH, abort that state with no residual pulse; after release the block is in RUN.

Structure
REQ-019 SHALL place the funct3 branch encodings, the FSM state typedef and the BHT counter reset constant in a shared package, riscv_pkg.
REQ-020 SHALL contain the comparator as one combinational sub-module, branch_cond_eval (rs1, rs2, funct3 -> taken); the BHT, FSM and counters stay in the top level.

Verification
REQ-021 SHALL cover the following directed scenarios:
- Reset, then if_pc=0x100 -> pred_taken=0; all counters 0; no flush.
- BEQ at pc 0x40, rs1=rs2=5, ex_pred_taken=0, target 0x80 -> next cycle redirect_valid=1, redirect_pc=0x80; mispred_count=1; entry 0 becomes 10; the following 3 EX branches are ignored.
- BLT rs1=0xFFFFFFFF, rs2=1 is taken; BLTU with the same operands is not taken -> the redirect targets are ex_target and ex_pc+4 respectively.
- Four taken BNE at one index -> counter saturates at 11; then one not-taken -> 10, pred_taken still 1.
- Mispredict followed by stall=1 for 5 cycles during SQUASH -> squash lasts 3 non-stalled cycles, and br_count is unchanged during the squash.
- rst_n pulsed low during SQUASH -> all outputs at reset values immediately; the next mispredict after release redirects normally.
